// File: rtl/universal_ff_bank_pkg.sv
// Shared definitions for the universal flip-flop bank: mode encodings and the
// per-bit next-state rule used by every storage cell.
package universal_ff_bank_pkg;

    localparam logic [1:0] FF_MODE_SR = 2'b00;
    localparam logic [1:0] FF_MODE_JK = 2'b01;
    localparam logic [1:0] FF_MODE_D  = 2'b10;
    localparam logic [1:0] FF_MODE_T  = 2'b11;

    // SR 11 is forbidden and resolves to hold; the error flag is raised separately.
    function automatic logic ff_next(input logic [1:0] mode, input logic q,
                                     input logic a, input logic b);
        logic nxt;
        nxt = q;
        case (mode)
            FF_MODE_SR: begin
                if (a && !b)      nxt = 1'b1;
                else if (!a && b) nxt = 1'b0;
                else              nxt = q;
            end
            FF_MODE_JK: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            FF_MODE_D: nxt = a;
            FF_MODE_T: nxt = a ? ~q : q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/universal_ff_bank_if.sv
// Control/data bundle between a driver and the universal flip-flop bank.
interface universal_ff_bank_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) ();
    logic               en;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               clr_err;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   qbar;
    logic [WIDTH-1:0]   changed;
    logic               err;
    logic               err_sticky;
    logic [COUNT_W-1:0] err_count;

    modport master (
        output en, mode, a, b, clr_err,
        input  q, qbar, changed, err, err_sticky, err_count
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qbar, changed, err, err_sticky, err_count
    );
endinterface

// File: rtl/universal_ff_bank_cell.sv
// One storage bit with runtime-selectable SR/JK/D/T behaviour and a change pulse.
module universal_ff_cell
    import universal_ff_bank_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       chg,
    output logic       forbid
);
    logic q_d, q_q;
    logic chg_d, chg_q;

    always_comb begin
        q_d = q_q;
        if (en) q_d = ff_next(mode, q_q, a, b);
        chg_d = q_d ^ q_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q   <= init;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign forbid = en & (mode == FF_MODE_SR) & a & b;
    assign q      = q_q;
    assign chg    = chg_q;
endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-bit bank of universal flip-flops plus forbidden-SR error tracking
// (pulse, sticky flag, saturating counter).
module universal_ff_bank
    import universal_ff_bank_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter int               COUNT_W = 8
) (
    input logic                clock,
    input logic                reset,
    universal_ff_bank_if.slave bus
);
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic [WIDTH-1:0]   q_vec;
    logic [WIDTH-1:0]   chg_vec;
    logic [WIDTH-1:0]   forbid_vec;
    logic               err_d, err_q;
    logic               sticky_d, sticky_q;
    logic [COUNT_W-1:0] count_d, count_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        universal_ff_cell u_cell (
            .clock  (clock),
            .reset  (reset),
            .init   (INIT[i]),
            .en     (bus.en),
            .mode   (bus.mode),
            .a      (bus.a[i]),
            .b      (bus.b[i]),
            .q      (q_vec[i]),
            .chg    (chg_vec[i]),
            .forbid (forbid_vec[i])
        );
    end

    // Clear is applied first so an error in the same cycle still registers.
    always_comb begin
        err_d    = |forbid_vec;
        sticky_d = bus.clr_err ? 1'b0 : sticky_q;
        count_d  = bus.clr_err ? '0 : count_q;
        if (err_d) begin
            sticky_d = 1'b1;
            if (count_d != CNT_MAX) count_d = count_d + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            err_q    <= err_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign bus.q          = q_vec;
    assign bus.qbar       = ~q_vec;
    assign bus.changed    = chg_vec;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = count_q;
endmodule
